classify_led: RTL
=================

CLASSIFY_LED -- requirements
Module: classify_led

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of class scores per result vector; legal range 2..256.
REQ-002 Parameter SCORE_W, default 16, width of one signed two's-complement score.
REQ-003 Parameter LED_W, default 4, number of LED outputs.
REQ-004 Parameter HOLD_CYCLES, default 33000000, display hold time in clk cycles (1 s at 33 MHz).
REQ-005 Parameter LED_MODE, default 0, display encoding: 0 = binary index, 1 = one-hot index.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 in_valid  input  1  score vector on in_score is valid.
REQ-009 in_ready  output  1  block can accept a vector this cycle.
REQ-010 in_score  input  NUM_CLASSES*SCORE_W  packed scores; class i occupies bits [i*SCORE_W +: SCORE_W].
REQ-011 class_idx  output  IDX_W = clog2(NUM_CLASSES)  index of the winning class.
REQ-012 class_valid  output  1  one-cycle pulse when class_idx updates.
REQ-013 busy  output  1  high in SCAN state.
REQ-014 led  output  LED_W  registered display of the winning class.

Function
REQ-015 The FSM SHALL have three states: IDLE, SCAN and HOLD.
REQ-016 in_ready SHALL be high in IDLE and HOLD, and low in SCAN.
REQ-017 An acceptance occurs on an edge where in_valid and in_ready are both high; in_score SHALL be captured into an internal register on that edge.
REQ-018 On acceptance, the block SHALL set best = score[0], best_idx = 0, ptr = 1 and state = SCAN.
REQ-019 Each SCAN edge SHALL compare score[ptr] with best as signed values.
REQ-020 If score[ptr] > best (strict), the block SHALL replace best and best_idx; ties SHALL keep the lower index.
REQ-021 ptr SHALL then increment.
REQ-022 On the edge that compares ptr = NUM_CLASSES-1, the block SHALL load class_idx with the final best_idx, pulse class_valid high for exactly one cycle, update led, clear the hold counter and enter HOLD.
REQ-023 Latency: class_valid SHALL be high in the cycle that follows the (NUM_CLASSES-1)th edge after the acceptance edge; for the default this is 9 edges after acceptance.
REQ-024 In HOLD, the hold counter SHALL increment every cycle; when it reaches HOLD_CYCLES-1, the next edge SHALL enter IDLE.
REQ-025 The counter width SHALL be clog2(HOLD_CYCLES)+1.
REQ-026 An acceptance in HOLD SHALL start a new SCAN immediately, abandoning the hold; led and class_idx keep their old values until the new result.
REQ-027 In IDLE after a hold expires, led SHALL blank to all zeros; class_idx SHALL retain its last value.
REQ-028 LED_MODE 0: led SHALL equal class_idx zero-extended, or truncated to its low LED_W bits when IDX_W > LED_W.
REQ-029 LED_MODE 1: led[class_idx] SHALL be 1 when class_idx < LED_W; otherwise led SHALL be all ones (overflow indication).
REQ-030 in_valid while busy SHALL be ignored; no queuing.
REQ-031 Captured scores SHALL be unaffected by in_score changes during SCAN.

Reset
REQ-032 While rst is high at an edge: state = IDLE, class_idx = 0, class_valid = 0, busy = 0, led = 0, hold counter = 0, ptr = 0, best = 0.
REQ-033 in_ready SHALL be 0 during reset and 1 from the first edge after rst falls.
REQ-034 rst asserted mid-SCAN or mid-HOLD SHALL abort with no class_valid pulse.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE/SCAN/HOLD), the LED_MODE constants and the clog2-based IDX_W helper.
REQ-036 One sub-module, led_encode, SHALL be used: combinational index-to-LED mapping per LED_MODE, whose result is registered in classify_led.
REQ-037 NUM_CLASSES < 2 SHALL be rejected by an elaboration-time check.

Verification
REQ-038 Defaults, scores 0..9 = {5,3,9,1,0,-2,7,9,4,2}, accept at edge 0 -> class_valid high after edge 9, class_idx = 2 (tie with 7 resolved low), led = 4'b0010.
REQ-039 All scores = -32768 except class 9 = -32767 -> class_idx = 9, led = 4'b1001; LED_MODE 1 -> led = 4'b1111.
REQ-040 HOLD_CYCLES = 20, one result -> led nonzero for exactly 20 cycles after class_valid, then 0; in_ready high throughout HOLD.
REQ-041 in_valid held high continuously -> in_ready low for 9 cycles per vector, one class_valid per accepted vector, no dropped or duplicated results.
REQ-042 rst pulsed at scan edge 4 -> no class_valid, all outputs 0 next cycle, and a new vector accepted correctly afterwards.
REQ-043 NUM_CLASSES = 3, SCORE_W = 8, scores {-1,-1,-1} -> class_idx = 0, class_valid 2 edges after acceptance.

Source files
------------

// File: rtl/classify_led_pkg.sv
// rtl/classify_led_pkg.sv - shared state type, display-mode constants and index-width helper
package classify_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int LED_MODE_BINARY = 0;
  localparam int LED_MODE_ONEHOT = 1;

  // Width of a class index; never below one bit so ports stay legal.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/classify_led_led_encode.sv
// rtl/classify_led_led_encode.sv - combinational class-index to LED pattern mapping
module led_encode
  import classify_led_pkg::*;
#(
  parameter int IDX_W    = 4,
  parameter int LED_W    = 4,
  parameter int LED_MODE = LED_MODE_BINARY
) (
  input  logic [IDX_W-1:0] idx,
  output logic [LED_W-1:0] led
);

  // Binary mode zero-extends or truncates; one-hot saturates to all ones when the index has no LED.
  always_comb begin
    led = LED_W'(idx);
    if (LED_MODE == LED_MODE_ONEHOT) begin
      if (32'(idx) < 32'(LED_W)) begin
        led = LED_W'(1) << idx;
      end else begin
        led = '1;
      end
    end
  end

endmodule

// File: rtl/classify_led.sv
// rtl/classify_led.sv - argmax over a captured score vector, shown on LEDs for a hold time
module classify_led
  import classify_led_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16,
  parameter int LED_W       = 4,
  parameter int HOLD_CYCLES = 33000000,
  parameter int LED_MODE    = LED_MODE_BINARY
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_CLASSES*SCORE_W-1:0]       in_score,
  output logic [idx_width(NUM_CLASSES)-1:0]    class_idx,
  output logic                                 class_valid,
  output logic                                 busy,
  output logic [LED_W-1:0]                     led
);

  localparam int IDX_W = idx_width(NUM_CLASSES);
  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  if (NUM_CLASSES < 2) begin : g_bad_num_classes
    $error("classify_led: NUM_CLASSES must be at least 2");
  end

  state_t                     state;
  logic signed [SCORE_W-1:0]  score_q [NUM_CLASSES];
  logic signed [SCORE_W-1:0]  best;
  logic        [IDX_W-1:0]    best_idx;
  logic        [IDX_W-1:0]    ptr;
  logic        [CNT_W-1:0]    hold_cnt;

  logic                       accept;
  logic signed [SCORE_W-1:0]  cur_score;
  logic                       take;
  logic        [IDX_W-1:0]    win_idx;
  logic        [LED_W-1:0]    led_next;

  assign accept    = in_valid & in_ready & ~rst;
  assign cur_score = score_q[ptr];
  // Strict compare so ties keep the earlier (lower) index.
  assign take      = cur_score > best;
  assign win_idx   = take ? ptr : best_idx;

  led_encode #(
    .IDX_W    (IDX_W),
    .LED_W    (LED_W),
    .LED_MODE (LED_MODE)
  ) u_led_encode (
    .idx (win_idx),
    .led (led_next)
  );

  // Snapshot the whole vector on acceptance so later in_score changes cannot disturb a scan.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        score_q[i] <= in_score[i*SCORE_W +: SCORE_W];
      end
    end
  end

  // Control FSM: accept, walk one class per cycle, publish result, then hold the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      class_idx   <= '0;
      class_valid <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      led         <= '0;
      hold_cnt    <= '0;
      ptr         <= '0;
      best        <= '0;
      best_idx    <= '0;
    end else begin
      class_valid <= 1'b0;
      if (accept) begin
        best     <= in_score[SCORE_W-1:0];
        best_idx <= '0;
        ptr      <= IDX_W'(1);
        state    <= SCAN;
        busy     <= 1'b1;
        in_ready <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            in_ready <= 1'b1;
          end
          SCAN: begin
            if (take) begin
              best     <= cur_score;
              best_idx <= ptr;
            end
            if (ptr == LAST_IDX) begin
              ptr         <= '0;
              class_idx   <= win_idx;
              class_valid <= 1'b1;
              led         <= led_next;
              hold_cnt    <= '0;
              state       <= HOLD;
              busy        <= 1'b0;
              in_ready    <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
          HOLD: begin
            in_ready <= 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              state <= IDLE;
              led   <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
